// File: rtl/pulse_train_generator_if.sv
// pulse_train_generator_if: control and status bundle for pulse_train_generator.
// The master side requests trains and supplies the configuration. The slave side
// drives the serial line and the status flags.
// The optional abort line is present only when PULSE_GEN_ABORT_EN is defined.
interface pulse_train_generator_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] pulse_width;
  logic [W-1:0] gap_width;
  logic [W-1:0] pulse_count;
`ifdef PULSE_GEN_ABORT_EN
  logic         abort;
`endif
  logic         out;
  logic         busy;
  logic         done;

`ifdef PULSE_GEN_ABORT_EN
  modport master (
    output start, pulse_width, gap_width, pulse_count, abort,
    input  out, busy, done
  );
  modport slave (
    input  start, pulse_width, gap_width, pulse_count, abort,
    output out, busy, done
  );
`else
  modport master (
    output start, pulse_width, gap_width, pulse_count,
    input  out, busy, done
  );
  modport slave (
    input  start, pulse_width, gap_width, pulse_count,
    output out, busy, done
  );
`endif
endinterface

// File: rtl/pulse_train_generator.sv
// pulse_train_generator: drives a serial line with pulse_count high pulses.
// Each pulse is pulse_width cycles long, and pulses are separated by gaps of
// gap_width low cycles. There is no trailing gap. A one-cycle done strobe
// follows the last high cycle.
// Width and gap fields of 0 behave as 1. A count of 0 gives an empty train,
// which produces only a done strobe.
// Optional feature macro: PULSE_GEN_ABORT_EN adds an abort input. The abort
// input ends a running train without a done strobe.
module pulse_train_generator #(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  pulse_train_generator_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  // A zero length field is promoted to one cycle.
  function automatic logic [W-1:0] eff_len(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v == CNT_ZERO) begin
      r = CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [1:0]   state_q,  state_d;
  logic [W-1:0] timer_q,  timer_d;   // cycles left in the current HIGH/GAP phase
  logic [W-1:0] pulses_q, pulses_d;  // pulses left, including the current one
  logic [W-1:0] width_q,  width_d;   // latched effective pulse width
  logic [W-1:0] gap_q,    gap_d;     // latched effective gap width
  logic         out_q,    out_d;
  logic         busy_q,   busy_d;
  logic         done_q,   done_d;
  logic         abort_s;

`ifdef PULSE_GEN_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Next-state logic. Configuration is captured only when a start is accepted in IDLE.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pulses_d = pulses_q;
    width_d  = width_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          width_d = eff_len(bus.pulse_width);
          gap_d   = eff_len(bus.gap_width);
          if (bus.pulse_count == CNT_ZERO) begin
            state_d  = ST_IDLE;
            timer_d  = CNT_ZERO;
            pulses_d = CNT_ZERO;
            done_d   = 1'b1;
          end else begin
            state_d  = ST_HIGH;
            timer_d  = eff_len(bus.pulse_width);
            pulses_d = bus.pulse_count;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (abort_s) begin
          state_d  = ST_IDLE;
          timer_d  = CNT_ZERO;
          pulses_d = CNT_ZERO;
        end else if (timer_q == CNT_ONE) begin
          if (pulses_q == CNT_ONE) begin
            state_d  = ST_IDLE;
            timer_d  = CNT_ZERO;
            pulses_d = CNT_ZERO;
            done_d   = 1'b1;
          end else begin
            state_d = ST_GAP;
            timer_d = gap_q;
          end
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (abort_s) begin
          state_d  = ST_IDLE;
          timer_d  = CNT_ZERO;
          pulses_d = CNT_ZERO;
        end else if (timer_q == CNT_ONE) begin
          state_d  = ST_HIGH;
          timer_d  = width_q;
          pulses_d = pulses_q - CNT_ONE;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        timer_d  = CNT_ZERO;
        pulses_d = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state, so the output flops line up with the state.
  always_comb begin
    out_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and output registers. The async reset returns the block to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= CNT_ZERO;
      pulses_q <= CNT_ZERO;
      width_q  <= CNT_ZERO;
      gap_q    <= CNT_ZERO;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pulses_q <= pulses_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed and random checks of pulse_train_generator.
// An accepted start queues the whole expected per-cycle {out,busy,done}
// waveform, built from the train rules.
module tb_pulse_train_generator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  // Expected per-cycle {out, busy, done} for the cycles ahead, plus the current cycle.
  logic [2:0] exp_q[$];
  logic [2:0] cur;

  pulse_train_generator_if #(.W(W)) bus ();

  pulse_train_generator #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Build the whole waveform of one accepted train.
  task automatic model_accept(input int pw, input int gw, input int pc);
    int p;
    int g;
    p = (pw == 0) ? 1 : pw;
    g = (gw == 0) ? 1 : gw;
    for (int i = 0; i < pc; i++) begin
      for (int j = 0; j < p; j++) exp_q.push_back(3'b110);
      if (i != pc - 1) begin
        for (int j = 0; j < g; j++) exp_q.push_back(3'b010);
      end
    end
    exp_q.push_back(3'b001);
  endtask

  // Advance one clock, update the reference, and compare all three outputs.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (cur[1] == 1'b0 && bus.start === 1'b1) begin
      model_accept(int'(bus.pulse_width), int'(bus.gap_width), int'(bus.pulse_count));
    end
`ifdef PULSE_GEN_ABORT_EN
    else if (cur[1] == 1'b1 && bus.abort === 1'b1) begin
      exp_q.delete();
    end
`endif
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    #1;
    check_bit({tag, ".out"},  bus.out,  cur[2]);
    check_bit({tag, ".busy"}, bus.busy, cur[1]);
    check_bit({tag, ".done"}, bus.done, cur[0]);
  endtask

  task automatic set_cfg(input logic s, input int pw, input int gw, input int pc);
    bus.start       = s;
    bus.pulse_width = W'(pw);
    bus.gap_width   = W'(gw);
    bus.pulse_count = W'(pc);
  endtask

  initial begin
    logic [6:0] pat7;
    logic [6:0] don7;
    logic [8:0] pat9;
    logic [8:0] don9;
    logic [4:0] pat5;
    logic [4:0] don5;
    int         highs;
    int         rises;
    logic       prev;

    cur = 3'b000;
    rst = 1'b0;
    set_cfg(1'b1, 3, 3, 3);
`ifdef PULSE_GEN_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset held with start high: everything stays low.
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst.out",  bus.out,  1'b0);
    check_bit("rst.busy", bus.busy, 1'b0);
    check_bit("rst.done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_cfg(1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("idle");

    // Width 1, gap 1, count 3.
    pat7 = 7'b1010100;
    don7 = 7'b0000010;
    set_cfg(1'b1, 1, 1, 3);
    for (int i = 0; i < 7; i++) begin
      cycle("w1g1c3");
      bus.start = 1'b0;
      check_bit("w1g1c3.pat_out",  bus.out,  pat7[6-i]);
      check_bit("w1g1c3.pat_done", bus.done, don7[6-i]);
    end

    // Width 2, gap 3, count 2; a start and a width change mid-train are ignored.
    pat9 = 9'b110001100;
    don9 = 9'b000000010;
    set_cfg(1'b1, 2, 3, 2);
    for (int i = 0; i < 9; i++) begin
      cycle("w2g3c2");
      if (i == 0) bus.start = 1'b0;
      if (i == 2) begin
        bus.start       = 1'b1;
        bus.pulse_width = 8'd5;
      end
      if (i == 4) bus.start = 1'b0;
      check_bit("w2g3c2.pat_out",  bus.out,  pat9[8-i]);
      check_bit("w2g3c2.pat_done", bus.done, don9[8-i]);
    end

    // Empty train: done only, next cycle.
    set_cfg(1'b1, 0, 0, 0);
    cycle("empty");
    check_bit("empty.done1", bus.done, 1'b1);
    check_bit("empty.busy1", bus.busy, 1'b0);
    bus.start = 1'b0;
    cycle("empty_after");
    check_bit("empty.done2", bus.done, 1'b0);

    // Zero width and gap, count 2: out = 1,0,1 then done.
    pat5 = 5'b10100;
    don5 = 5'b00010;
    set_cfg(1'b1, 0, 0, 2);
    for (int i = 0; i < 5; i++) begin
      cycle("w0g0c2");
      bus.start = 1'b0;
      check_bit("w0g0c2.pat_out",  bus.out,  pat5[4-i]);
      check_bit("w0g0c2.pat_done", bus.done, don5[4-i]);
    end

    // Back-to-back: start held through the done cycle restarts at once.
    pat5 = 5'b10100;
    don5 = 5'b01010;
    set_cfg(1'b1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cycle("b2b");
      if (i == 2) bus.start = 1'b0;
      check_bit("b2b.pat_out",  bus.out,  pat5[4-i]);
      check_bit("b2b.pat_done", bus.done, don5[4-i]);
    end

    // Reset during the second gap of a count-4 train, then a normal train.
    set_cfg(1'b1, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      cycle("midrst");
      bus.start = 1'b0;
    end
    check_bit("midrst.in_gap_busy", bus.busy, 1'b1);
    check_bit("midrst.in_gap_out",  bus.out,  1'b0);
    rst = 1'b0;
    #1;
    exp_q.delete();
    cur = 3'b000;
    check_bit("midrst.out",  bus.out,  1'b0);
    check_bit("midrst.busy", bus.busy, 1'b0);
    check_bit("midrst.done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    set_cfg(1'b1, 1, 1, 1);
    cycle("after_rst");
    bus.start = 1'b0;
    check_bit("after_rst.out", bus.out, 1'b1);
    cycle("after_rst");
    check_bit("after_rst.done", bus.done, 1'b1);

`ifdef PULSE_GEN_ABORT_EN
    // Abort in the first HIGH cycle of a width-4 pulse: no done.
    set_cfg(1'b1, 4, 1, 2);
    cycle("abort");
    bus.start = 1'b0;
    check_bit("abort.first_high", bus.out, 1'b1);
    bus.abort = 1'b1;
    cycle("abort");
    bus.abort = 1'b0;
    check_bit("abort.out",  bus.out,  1'b0);
    check_bit("abort.busy", bus.busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("abort_after");
      check_bit("abort.no_done", bus.done, 1'b0);
    end
`endif

    // Maximum width: exactly 255 high cycles.
    set_cfg(1'b1, 255, 1, 1);
    highs = 0;
    for (int i = 0; i < 258; i++) begin
      cycle("maxw");
      bus.start = 1'b0;
      if (bus.out === 1'b1) highs++;
    end
    check_int("maxw.high_cycles", highs, 255);

    // Maximum count: exactly 255 pulses.
    set_cfg(1'b1, 1, 1, 255);
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 512; i++) begin
      cycle("maxc");
      bus.start = 1'b0;
      if (bus.out === 1'b1 && prev == 1'b0) rises++;
      prev = bus.out;
    end
    check_int("maxc.pulses", rises, 255);

    // Random trains with starts sprinkled in, including while busy.
    for (int i = 0; i < 600; i++) begin
      bus.start       = ($urandom_range(0, 3) == 0);
      bus.pulse_width = W'($urandom_range(0, 4));
      bus.gap_width   = W'($urandom_range(0, 4));
      bus.pulse_count = W'($urandom_range(0, 4));
`ifdef PULSE_GEN_ABORT_EN
      bus.abort       = ($urandom_range(0, 19) == 0);
`endif
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
